fetch_sequencer: RTL and testbench



---
 rtl/fetch_sequencer.sv | 116 +++++++++++
 tb/tb_fetch_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Program-counter controller for the instruction ROM. Handles
//               start/stall/halt/jump/branch and keeps run statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter int ADDR_W       = 8,
  parameter int CNT_W        = 16,
  parameter int HALT_ON_WRAP = 1
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [ADDR_W-1:0] StartAddress,
  input  logic              Stall,
  input  logic              Halt,
  input  logic              JumpEn,
  input  logic [ADDR_W-1:0] JumpTarget,
  input  logic              BranchEn,
  input  logic [ADDR_W-1:0] BranchOffset,
  output logic [ADDR_W-1:0] InstrAddress,
  output logic              InstrValid,
  output logic              Done,
  output logic              Fault,
  output logic [CNT_W-1:0]  CycleCount,
  output logic [CNT_W-1:0]  InstrCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fault_q, fault_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      fault_q     <= 1'b0;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fault_q     <= fault_d;
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fault_d     = fault_q;
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;

    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d     = RUN;
          pc_d        = StartAddress;
          fault_d     = 1'b0;
          cycle_cnt_d = '0;
          instr_cnt_d = '0;
        end
      end

      RUN: begin
        if (cycle_cnt_q != CNT_MAX) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        if (!Stall) begin
          if (instr_cnt_q != CNT_MAX) instr_cnt_d = instr_cnt_q + CNT_W'(1);
          if (Halt) begin
            state_d = DONE;
          end else if (JumpEn) begin
            pc_d = JumpTarget;
          end else if (BranchEn) begin
            // Same-width add is the sign-extended offset modulo 2^ADDR_W.
            pc_d = pc_q + BranchOffset;
          end else if (pc_q == PC_MAX) begin
            if (HALT_ON_WRAP != 0) begin
              state_d = DONE;
              fault_d = 1'b1;
            end else begin
              pc_d = '0;
            end
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign InstrAddress = pc_q;
  assign InstrValid   = (state_q == RUN);
  assign Done         = (state_q == DONE);
  assign Fault        = fault_q;
  assign CycleCount   = cycle_cnt_q;
  assign InstrCount   = instr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Scoreboard bench for fetch_sequencer, with a second instance
//               built for PC wrap-around and narrow saturating counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  logic       CLK = 1'b0;
  logic       Reset_n;
  logic       Start, Stall, Halt, JumpEn, BranchEn;
  logic [7:0] StartAddress, JumpTarget, BranchOffset;

  logic [7:0]  InstrAddress;
  logic        InstrValid, Done, Fault;
  logic [15:0] CycleCount, InstrCount;

  logic [7:0]  w_addr;
  logic        w_valid, w_done, w_fault;
  logic [3:0]  w_cyc, w_ins;

  always #5 CLK = ~CLK;

  fetch_sequencer #(.ADDR_W(8), .CNT_W(16), .HALT_ON_WRAP(1)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .StartAddress(StartAddress),
    .Stall(Stall), .Halt(Halt), .JumpEn(JumpEn), .JumpTarget(JumpTarget),
    .BranchEn(BranchEn), .BranchOffset(BranchOffset),
    .InstrAddress(InstrAddress), .InstrValid(InstrValid), .Done(Done),
    .Fault(Fault), .CycleCount(CycleCount), .InstrCount(InstrCount)
  );

  fetch_sequencer #(.ADDR_W(8), .CNT_W(4), .HALT_ON_WRAP(0)) dut_w (
    .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .StartAddress(StartAddress),
    .Stall(Stall), .Halt(Halt), .JumpEn(JumpEn), .JumpTarget(JumpTarget),
    .BranchEn(BranchEn), .BranchOffset(BranchOffset),
    .InstrAddress(w_addr), .InstrValid(w_valid), .Done(w_done),
    .Fault(w_fault), .CycleCount(w_cyc), .InstrCount(w_ins)
  );

  typedef struct packed {
    logic [7:0]  pc;
    logic        valid;
    logic        done;
    logic        fault;
    logic [15:0] cyc;
    logic [15:0] ins;
  } exp_t;

  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of the main instance (0=IDLE, 1=RUN, 2=DONE).
  int          m_state;
  logic [7:0]  m_pc;
  logic        m_fault;
  logic [15:0] m_cyc, m_ins;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pc = 8'h00; m_fault = 1'b0; m_cyc = 16'h0; m_ins = 16'h0;
  endtask

  task automatic model_step();
    case (m_state)
      0, 2: if (Start) begin
        m_state = 1; m_pc = StartAddress; m_fault = 1'b0; m_cyc = 16'h0; m_ins = 16'h0;
      end
      1: begin
        if (m_cyc != 16'hFFFF) m_cyc = m_cyc + 16'h1;
        if (!Stall) begin
          if (m_ins != 16'hFFFF) m_ins = m_ins + 16'h1;
          if (Halt) m_state = 2;
          else if (JumpEn) m_pc = JumpTarget;
          else if (BranchEn) m_pc = m_pc + BranchOffset;
          else if (m_pc == 8'hFF) begin m_state = 2; m_fault = 1'b1; end
          else m_pc = m_pc + 8'h1;
        end
      end
      default: m_state = 0;
    endcase
  endtask

  // Drive one cycle of requests, predict the result, then compare after the edge.
  task automatic step(input logic st, input logic [7:0] sa, input logic stl,
                      input logic hlt, input logic je, input logic [7:0] jt,
                      input logic be, input logic [7:0] bo);
    exp_t e;
    Start = st; StartAddress = sa; Stall = stl; Halt = hlt;
    JumpEn = je; JumpTarget = jt; BranchEn = be; BranchOffset = bo;
    model_step();
    e.pc = m_pc; e.valid = (m_state == 1); e.done = (m_state == 2);
    e.fault = m_fault; e.cyc = m_cyc; e.ins = m_ins;
    sb_q.push_back(e);
    @(posedge CLK); #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("pc",    32'(InstrAddress), 32'(e.pc));
      check("valid", 32'(InstrValid),   32'(e.valid));
      check("done",  32'(Done),         32'(e.done));
      check("fault", 32'(Fault),        32'(e.fault));
      check("cyc",   32'(CycleCount),   32'(e.cyc));
      check("ins",   32'(InstrCount),   32'(e.ins));
    end
  endtask

  task automatic nop();          step(0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00); endtask
  task automatic start(input logic [7:0] a); step(1, a, 0, 0, 0, 8'h00, 0, 8'h00); endtask

  initial begin
    Reset_n = 1'b0; Start = 0; Stall = 0; Halt = 0; JumpEn = 0; BranchEn = 0;
    StartAddress = 0; JumpTarget = 0; BranchOffset = 0;
    model_reset();
    #2;
    check("rst_pc",    32'(InstrAddress), 32'h0);
    check("rst_valid", 32'(InstrValid),   32'h0);
    check("rst_done",  32'(Done),         32'h0);
    #10 Reset_n = 1'b1;
    nop();
    nop();

    // Straight-line run ending in Halt
    start(8'h10);
    check("seq0", 32'(InstrAddress), 32'h10);
    nop(); check("seq1", 32'(InstrAddress), 32'h11);
    nop(); check("seq2", 32'(InstrAddress), 32'h12);
    nop(); check("seq3", 32'(InstrAddress), 32'h13);
    step(0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00);
    check("seq_done", 32'(Done), 32'h1);
    check("seq_ins",  32'(InstrCount), 32'd4);
    check("seq_cyc",  32'(CycleCount), 32'd4);

    // Stalls hold the PC and mask halt/jump, then a jump
    start(8'h05);
    step(0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00);
    step(0, 8'h00, 1, 1, 1, 8'h77, 0, 8'h00);
    check("stall_hold", 32'(InstrAddress), 32'h05);
    step(0, 8'h00, 0, 0, 1, 8'h80, 0, 8'h00);
    check("jump_pc",  32'(InstrAddress), 32'h80);
    check("jump_ins", 32'(InstrCount), 32'd1);
    check("jump_cyc", 32'(CycleCount), 32'd3);
    step(0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00);

    // Relative branches wrapping both ways
    start(8'h02);
    step(0, 8'h00, 0, 0, 0, 8'h00, 1, 8'hFC);
    check("br_back", 32'(InstrAddress), 32'hFE);
    check("br_nofault", 32'(Fault), 32'h0);
    step(0, 8'h00, 0, 0, 1, 8'hF0, 0, 8'h00);
    step(0, 8'h00, 0, 0, 0, 8'h00, 1, 8'h20);
    check("br_fwd", 32'(InstrAddress), 32'h10);
    step(0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00);

    // All requests at once: halt wins; then restart from DONE
    start(8'h33);
    nop();
    step(0, 8'h00, 0, 1, 1, 8'h99, 1, 8'h05);
    check("prio_done", 32'(Done), 32'h1);
    check("prio_pc", 32'(InstrAddress), 32'h34);
    start(8'h40);
    check("restart_done", 32'(Done), 32'h0);
    check("restart_pc", 32'(InstrAddress), 32'h40);
    check("restart_cyc", 32'(CycleCount), 32'h0);

    // Asynchronous reset in the middle of a run
    step(0, 8'h00, 0, 0, 1, 8'h23, 0, 8'h00);
    check("pre_rst_pc", 32'(InstrAddress), 32'h23);
    #3 Reset_n = 1'b0;
    #1;
    model_reset();
    check("arst_pc",    32'(InstrAddress), 32'h0);
    check("arst_valid", 32'(InstrValid),   32'h0);
    check("arst_cyc",   32'(CycleCount),   32'h0);
    check("arst_ins",   32'(InstrCount),   32'h0);
    #2 Reset_n = 1'b1;
    nop();
    nop();
    check("post_rst_valid", 32'(InstrValid), 32'h0);

    // End of ROM: fault on the main instance, wrap on the other
    start(8'hFE);
    check("w0", 32'(w_addr), 32'hFE);
    nop();
    check("w1_main", 32'(InstrAddress), 32'hFF);
    check("w1_wrap", 32'(w_addr), 32'hFF);
    nop();
    check("wrap_fault", 32'(Fault), 32'h1);
    check("wrap_done", 32'(Done), 32'h1);
    check("wrap_pc", 32'(InstrAddress), 32'hFF);
    check("wrap_addr0", 32'(w_addr), 32'h00);
    check("wrap_run", 32'(w_valid), 32'h1);
    check("wrap_nofault", 32'(w_fault), 32'h0);
    for (int i = 3; i <= 20; i++) begin
      nop();
      check("sat_cyc", 32'(w_cyc), (i > 15) ? 32'd15 : 32'(i));
      check("sat_ins", 32'(w_ins), (i > 15) ? 32'd15 : 32'(i));
      check("sat_addr", 32'(w_addr), 32'((8'hFE + i) & 8'hFF));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
